// File: rtl/vc_fifo_bank_pkg.sv
// Shared QoS definitions for the VC FIFO bank and the WRR arbiter.
// VC count, index width, default word width, pointer sizing.
package vc_fifo_bank_pkg;

  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;
  localparam int DATA_W_DEF = 6;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-clock circular FIFO for one virtual channel.
// Head word is exposed combinationally; flags derive from the count.
module vc_fifo
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  // A full FIFO still accepts a write when the head leaves the same cycle;
  // an empty FIFO never bypasses a concurrent write to the reader.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty        = (count == '0);
  assign full         = (count == FULL_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign head         = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// Four per-VC FIFOs feeding the WRR arbiter; pops the VC named by sel
// into a registered output with aligned overflow/underflow pulses.
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              push,
  input  logic [VC_W-1:0]   push_vc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [VC_W-1:0]   sel,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [NUM_VC-1:0] empty,
  output logic [NUM_VC-1:0] full,
  output logic [NUM_VC-1:0] almost_full,
  output logic [NUM_VC-1:0] almost_empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  logic [DATA_W-1:0] head [NUM_VC];
  logic [NUM_VC-1:0] push_dec;
  logic [NUM_VC-1:0] pop_dec;
  logic              push_hit;
  logic              pop_hit;
  logic              pop_ok;
  logic              ovf;

  assign push_hit = enb && push;
  assign pop_hit  = enb && pop;
  assign pop_ok   = pop_hit && !empty[sel];
  assign ovf      = push_hit && full[push_vc]
                 && !(pop_hit && (sel == push_vc));

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign push_dec[i] = push_hit && (push_vc == VC_W'(i));
    assign pop_dec[i]  = pop_hit && (sel == VC_W'(i));

    vc_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push_dec[i]),
      .pop          (pop_dec[i]),
      .data_in      (data_in),
      .head         (head[i]),
      .empty        (empty[i]),
      .full         (full[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out      <= '0;
      valid_out     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      valid_out     <= pop_ok;
      err_overflow  <= ovf;
      err_underflow <= pop_hit && empty[sel];
      if (pop_ok) begin
        data_out <= head[sel];
      end
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Scoreboard bench for vc_fifo_bank: directed stimulus queues expected
// words; a monitor pops and compares every valid_out beat.
module tb_vc_fifo_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       enb;
  logic       push;
  logic [1:0] push_vc;
  logic [5:0] data_in;
  logic       pop;
  logic [1:0] sel;
  logic [5:0] data_out;
  logic       valid_out;
  logic [3:0] empty;
  logic [3:0] full;
  logic [3:0] almost_full;
  logic [3:0] almost_empty;
  logic       err_overflow;
  logic       err_underflow;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  vc_fifo_bank dut (
    .clk           (clk),
    .reset         (reset),
    .enb           (enb),
    .push          (push),
    .push_vc       (push_vc),
    .data_in       (data_in),
    .pop           (pop),
    .sel           (sel),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .empty         (empty),
    .full          (full),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid beat must match the oldest queued word.
  always @(posedge clk) begin
    #1;
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got %0h expected none",
                 data_out);
      end else begin
        automatic logic [5:0] e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic cyc(input logic e, input logic ph,
                     input logic [1:0] pv, input logic [5:0] d,
                     input logic pp, input logic [1:0] s);
    enb = e; push = ph; push_vc = pv; data_in = d;
    pop = pp; sel = s;
    @(posedge clk);
    #1;
    enb = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic wr(input logic [1:0] vc, input logic [5:0] d);
    cyc(1'b1, 1'b1, vc, d, 1'b0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] s, input logic [5:0] e);
    exp_q.push_back(e);
    cyc(1'b1, 1'b0, 2'd0, 6'h0, 1'b1, s);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 6'h0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b1; enb = 1'b0; push = 1'b0; push_vc = 2'd0;
    data_in = 6'h0; pop = 1'b0; sel = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle();
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_ae", 32'(almost_empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_af", 32'(almost_full), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_errs", 32'({err_overflow, err_underflow}), 32'h0);

    wr(2'd2, 6'h11);
    chk("vc2_empty1", 32'(empty[2]), 32'h0);
    chk("vc2_ae1", 32'(almost_empty[2]), 32'h1);
    wr(2'd2, 6'h12);
    chk("vc2_ae2", 32'(almost_empty[2]), 32'h0);
    rd(2'd2, 6'h11);
    chk("vc2_empty_mid", 32'(empty[2]), 32'h0);
    rd(2'd2, 6'h12);
    chk("vc2_empty_end", 32'(empty[2]), 32'h1);

    wr(2'd1, 6'h21);
    wr(2'd1, 6'h22);
    wr(2'd1, 6'h23);
    chk("vc1_af3", 32'(almost_full[1]), 32'h1);
    chk("vc1_full3", 32'(full[1]), 32'h0);
    wr(2'd1, 6'h24);
    chk("vc1_full", 32'(full[1]), 32'h1);
    wr(2'd1, 6'h25);
    chk("ovf_pulse", 32'(err_overflow), 32'h1);
    idle();
    chk("ovf_clear", 32'(err_overflow), 32'h0);
    rd(2'd1, 6'h21);
    chk("vc1_notfull", 32'(full[1]), 32'h0);
    rd(2'd1, 6'h22);
    rd(2'd1, 6'h23);
    rd(2'd1, 6'h24);
    chk("vc1_empty", 32'(empty[1]), 32'h1);

    wr(2'd3, 6'h31);
    wr(2'd3, 6'h32);
    wr(2'd3, 6'h33);
    wr(2'd3, 6'h34);
    exp_q.push_back(6'h31);
    cyc(1'b1, 1'b1, 2'd3, 6'h35, 1'b1, 2'd3);
    chk("vc3_pp_ovf", 32'(err_overflow), 32'h0);
    chk("vc3_pp_full", 32'(full[3]), 32'h1);
    rd(2'd3, 6'h32);
    rd(2'd3, 6'h33);
    rd(2'd3, 6'h34);
    rd(2'd3, 6'h35);
    chk("vc3_empty", 32'(empty[3]), 32'h1);

    cyc(1'b1, 1'b1, 2'd0, 6'h2A, 1'b1, 2'd0);
    chk("udf_pulse", 32'(err_underflow), 32'h1);
    chk("udf_valid", 32'(valid_out), 32'h0);
    chk("udf_data_hold", 32'(data_out), 32'h35);
    chk("udf_vc0_cnt1", 32'({empty[0], almost_empty[0]}), 32'h1);
    idle();
    chk("udf_clear", 32'(err_underflow), 32'h0);
    rd(2'd0, 6'h2A);

    for (int v = 0; v < 4; v++) begin
      wr(2'(v), 6'(8 * v + 1));
      wr(2'(v), 6'(8 * v + 2));
    end
    chk("ld_ae", 32'(almost_empty), 32'h0);
    rd(2'd0, 6'h01);
    rd(2'd1, 6'h09);
    cyc(1'b0, 1'b0, 2'd0, 6'h0, 1'b1, 2'd2);
    chk("enb0_valid", 32'(valid_out), 32'h0);
    chk("enb0_data", 32'(data_out), 32'h09);
    cyc(1'b0, 1'b1, 2'd2, 6'h3F, 1'b1, 2'd2);
    chk("enb0_ae", 32'(almost_empty), 32'h3);
    chk("enb0_empty", 32'(empty), 32'h0);
    chk("enb0_errs", 32'({err_overflow, err_underflow}), 32'h0);
    rd(2'd2, 6'h11);
    rd(2'd3, 6'h19);
    rd(2'd0, 6'h02);
    rd(2'd1, 6'h0A);
    rd(2'd2, 6'h12);
    rd(2'd3, 6'h1A);
    chk("drain_empty", 32'(empty), 32'hF);

    wr(2'd0, 6'h05);
    wr(2'd1, 6'h06);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 2'd2, 6'h07, 1'b1, 2'd0);
    reset = 1'b0;
    chk("mid_rst_empty", 32'(empty), 32'hF);
    chk("mid_rst_valid", 32'(valid_out), 32'h0);
    chk("mid_rst_data", 32'(data_out), 32'h0);

    idle();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
